// File: rtl/c64_bus_ctrl.sv
// c64_bus_ctrl: 6510 I/O port, PLA banking and memory routing between the CPU bus and C64 memories.
// Define CHAR_ROM_EN to map the character ROM into $D000-$DFFF when CHAREN=0.
module c64_bus_ctrl #(
  parameter logic [7:0] RESET_DDR  = 8'h00,
  parameter logic [7:0] RESET_PORT = 8'h3F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_we,
  output logic [7:0]  cpu_di,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata,
  output logic [12:0] basic_addr,
  input  logic [7:0]  basic_rdata,
  output logic [12:0] kernal_addr,
  input  logic [7:0]  kernal_rdata,
  output logic [11:0] char_addr,
  input  logic [7:0]  char_rdata,
  output logic [11:0] io_addr,
  output logic        io_cs,
  output logic        io_we,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata,
  input  logic [5:0]  port_in,
  output logic [5:0]  port_out,
  output logic [5:0]  port_oe
);
  localparam logic [2:0] SEL_PORT   = 3'd0;
  localparam logic [2:0] SEL_RAM    = 3'd1;
  localparam logic [2:0] SEL_BASIC  = 3'd2;
  localparam logic [2:0] SEL_KERNAL = 3'd3;
  localparam logic [2:0] SEL_CHAR   = 3'd4;
  localparam logic [2:0] SEL_IO     = 3'd5;

  logic [7:0] ddr_q, ddr_d, data_q, data_d, port_rd_q, port_rd_d;
  logic [2:0] sel_q, sel_d;
  logic       loram, hiram, is_port, in_basic, in_kernal, d_mapped, io_sel, char_sel;

  // Undriven (input) port bits read as 1 through the pull-ups.
  assign loram = (ddr_q[0] & data_q[0]) | ~ddr_q[0];
  assign hiram = (ddr_q[1] & data_q[1]) | ~ddr_q[1];

  assign is_port   = cpu_ab[15:1] == 15'd0;
  assign in_basic  = cpu_ab[15:13] == 3'b101;
  assign in_kernal = cpu_ab[15:13] == 3'b111;
  assign d_mapped  = (cpu_ab[15:12] == 4'hD) & (loram | hiram);

`ifdef CHAR_ROM_EN
  logic charen;
  assign charen    = (ddr_q[2] & data_q[2]) | ~ddr_q[2];
  assign io_sel    = d_mapped & charen;
  assign char_sel  = d_mapped & ~charen;
  assign char_addr = cpu_ab[11:0];
`else
  logic unused_char;
  assign unused_char = ^char_rdata;
  assign io_sel      = d_mapped;
  assign char_sel    = 1'b0;
  assign char_addr   = 12'd0;
`endif

  assign ram_addr    = cpu_ab;
  assign ram_wdata   = cpu_do;
  assign basic_addr  = cpu_ab[12:0];
  assign kernal_addr = cpu_ab[12:0];
  assign io_addr     = cpu_ab[11:0];
  assign io_wdata    = cpu_do;
  assign io_cs       = io_sel;
  assign io_we       = cpu_we & io_sel;
  assign ram_we      = cpu_we & ~io_sel;
  assign port_out    = ddr_q[5:0] & data_q[5:0];
  assign port_oe     = ddr_q[5:0];

  always_comb begin
    ddr_d     = (cpu_we && cpu_ab == 16'h0000) ? cpu_do : ddr_q;
    data_d    = (cpu_we && cpu_ab == 16'h0001) ? cpu_do : data_q;
    sel_d     = is_port              ? SEL_PORT   :
                in_basic & loram & hiram ? SEL_BASIC :
                in_kernal & hiram    ? SEL_KERNAL :
                io_sel               ? SEL_IO     :
                char_sel             ? SEL_CHAR   : SEL_RAM;
    port_rd_d = !is_port ? port_rd_q :
                cpu_ab[0] ? {data_q[7:6], (ddr_q[5:0] & data_q[5:0]) | (~ddr_q[5:0] & port_in)} : ddr_q;
  end

  always_comb begin
    cpu_di = sel_q == SEL_PORT   ? port_rd_q    :
             sel_q == SEL_BASIC  ? basic_rdata  :
             sel_q == SEL_KERNAL ? kernal_rdata :
             sel_q == SEL_IO     ? io_rdata     :
`ifdef CHAR_ROM_EN
             sel_q == SEL_CHAR   ? char_rdata   :
`endif
             ram_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ddr_q     <= RESET_DDR;
      data_q    <= RESET_PORT;
      sel_q     <= SEL_RAM;
      port_rd_q <= 8'h00;
    end else begin
      ddr_q     <= ddr_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
      port_rd_q <= port_rd_d;
    end
  end
endmodule
